// File: rtl/imem_fetch_resp.sv
// ---------------------------------------------------------------------------
// imem_fetch_resp
//
// Instruction-memory responder at the far end of the PC fetch path. Word
// fetch addresses arrive over a valid/ready request channel. Each accepted
// fetch reads a local instruction RAM, then moves through a fixed-latency
// pipeline. The result {inst, addr, fault} is written into a small response
// FIFO and returned over a valid/ready response channel.
//
// A credit limit keeps the number of fetches in flight (pipeline plus FIFO)
// at or below FIFO_DEPTH, so the FIFO can never overflow even though the
// pipeline never stalls. flush drops every in-flight and buffered fetch. The
// load port writes the RAM and is honoured in every cycle, including during
// reset and flush.
//
// Ports
//   clk, reset                   clock and synchronous active-high reset
//   req_valid/req_ready/req_addr fetch request channel (byte address)
//   resp_valid/resp_ready        response channel handshake
//   resp_inst/resp_addr/resp_fault
//                                response payload; inst is a NOP on fault
//   flush                        discard all in-flight and buffered fetches
//   load_en/load_addr/load_data  RAM write port (word index = addr[31:2])
//   busy                         any fetch in the pipeline or the FIFO
//
// LATENCY is legal from 1 to 4. FIFO_DEPTH must be a power of two so the
// extra pointer bit wraps cleanly at 2*FIFO_DEPTH.
// ---------------------------------------------------------------------------
module imem_fetch_resp #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_inst,
    output logic [31:0] resp_addr,
    output logic        resp_fault,
    input  logic        flush,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        busy
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + LATENCY) + 1;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] DEPTH_W  = 32'(DEPTH_WORDS);
    localparam logic [CW-1:0] CREDITS = CW'(FIFO_DEPTH);

    // -----------------------------------------------------------------------
    // Instruction RAM
    // -----------------------------------------------------------------------
    logic [31:0] ram [DEPTH_WORDS];
    logic        load_hit;
    logic        load_lsb_unused;

    assign load_hit        = load_en && ({2'b00, load_addr[31:2]} < DEPTH_W);
    // The byte offset of a load is meaningless for a word RAM.
    assign load_lsb_unused = ^load_addr[1:0];

    // Not reset: program contents survive reset and flush.
    always_ff @(posedge clk) begin
        if (load_hit) begin
            ram[load_addr[AW+1:2]] <= load_data;
        end
    end

    // -----------------------------------------------------------------------
    // Fetch accept and RAM read
    // -----------------------------------------------------------------------
    logic          accept;
    logic          fault_now;
    logic [31:0]   inst_now;
    logic [CW-1:0] inflight;
    logic [CW-1:0] pipe_cnt;
    logic [PW:0]   fifo_cnt;

    assign req_ready = !reset && !flush && (inflight < CREDITS);
    assign accept    = req_valid && req_ready;

    assign fault_now = (req_addr[1:0] != 2'b00) ||
                       ({2'b00, req_addr[31:2]} >= DEPTH_W);

    // The read happens in the accept cycle, before any same-cycle load lands
    // at the edge, so a colliding load/fetch returns the old word. A faulting
    // fetch never uses the RAM output.
    assign inst_now = fault_now ? NOP_INST : ram[req_addr[AW+1:2]];

    // -----------------------------------------------------------------------
    // Fixed-latency pipeline. An entry accepted in cycle T must be visible at
    // the FIFO head in cycle T+LATENCY, so LATENCY-1 register stages sit
    // between the accept and the FIFO write.
    // -----------------------------------------------------------------------
    logic        wr_valid;
    logic [31:0] wr_inst;
    logic [31:0] wr_addr;
    logic        wr_fault;

    generate
        if (LATENCY == 1) begin : g_direct
            assign wr_valid = accept;
            assign wr_inst  = inst_now;
            assign wr_addr  = req_addr;
            assign wr_fault = fault_now;
            assign pipe_cnt = '0;
        end else begin : g_pipe
            localparam int NS = LATENCY - 1;

            logic        st_valid [NS];
            logic [31:0] st_inst  [NS];
            logic [31:0] st_addr  [NS];
            logic        st_fault [NS];

            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    for (int i = 0; i < NS; i++) begin
                        st_valid[i] <= 1'b0;
                    end
                end else begin
                    st_valid[0] <= accept;
                    for (int i = 1; i < NS; i++) begin
                        st_valid[i] <= st_valid[i-1];
                    end
                end
            end

            // Payload follows the valid bit; it carries no meaning when invalid.
            always_ff @(posedge clk) begin
                st_inst[0]  <= inst_now;
                st_addr[0]  <= req_addr;
                st_fault[0] <= fault_now;
                for (int i = 1; i < NS; i++) begin
                    st_inst[i]  <= st_inst[i-1];
                    st_addr[i]  <= st_addr[i-1];
                    st_fault[i] <= st_fault[i-1];
                end
            end

            always_comb begin
                pipe_cnt = '0;
                for (int i = 0; i < NS; i++) begin
                    pipe_cnt = pipe_cnt + CW'(st_valid[i]);
                end
            end

            assign wr_valid = st_valid[NS-1];
            assign wr_inst  = st_inst[NS-1];
            assign wr_addr  = st_addr[NS-1];
            assign wr_fault = st_fault[NS-1];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Response FIFO. Pointers carry one extra bit so full and empty are
    // distinguishable; the count is their difference.
    // -----------------------------------------------------------------------
    logic [31:0] fifo_inst  [FIFO_DEPTH];
    logic [31:0] fifo_addr  [FIFO_DEPTH];
    logic        fifo_fault [FIFO_DEPTH];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic        push;
    logic        pop;

    assign fifo_cnt   = wr_ptr - rd_ptr;
    assign resp_valid = (fifo_cnt != '0);

    // Credits guarantee a free slot for every pipeline entry, so push needs
    // no full check. flush freezes the consumer side for its cycle.
    assign push = wr_valid && !flush && !reset;
    assign pop  = resp_valid && resp_ready && !flush && !reset;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr[PW-1:0]]  <= wr_inst;
            fifo_addr[wr_ptr[PW-1:0]]  <= wr_addr;
            fifo_fault[wr_ptr[PW-1:0]] <= wr_fault;
        end
    end

    // Storage is not reset; the head is forced to zero whenever the FIFO is
    // empty so the payload is clean after reset and flush.
    assign resp_inst  = resp_valid ? fifo_inst[rd_ptr[PW-1:0]]  : '0;
    assign resp_addr  = resp_valid ? fifo_addr[rd_ptr[PW-1:0]]  : '0;
    assign resp_fault = resp_valid ? fifo_fault[rd_ptr[PW-1:0]] : 1'b0;

    // -----------------------------------------------------------------------
    // Credits and status
    // -----------------------------------------------------------------------
    assign inflight = CW'(fifo_cnt) + pipe_cnt;
    assign busy     = (inflight != '0);

endmodule
